// File: rtl/display_scheduler.sv
// Round-robin scheduler sharing one six-digit display between seven tagged sources.
// Each granted word is latched and held for DWELL_CYCLES before the next pending source is served.
module display_scheduler #(
    parameter int unsigned DWELL_CYCLES = 50000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [6:0]  req,
    input  logic [11:0] data0,
    input  logic [11:0] data1,
    input  logic [11:0] data2,
    input  logic [11:0] data3,
    input  logic [11:0] data4,
    input  logic [11:0] data5,
    input  logic [11:0] data6,
    input  logic        hold,
    input  logic        next,
    output logic [2:0]  mode,
    output logic [11:0] value,
    output logic [6:0]  grant,
    output logic        valid,
    output logic        err
);

    typedef enum logic [1:0] {
        IDLE,
        SHOW,
        WAIT
    } state_t;

    localparam logic [25:0] DWELL_LOAD = 26'(DWELL_CYCLES - 1);
    localparam logic [1:0]  TAG_ILLEGAL = 2'b11;

    state_t      state, state_nxt;
    logic [25:0] cnt, cnt_nxt;
    logic [2:0]  ptr, ptr_nxt;
    logic [2:0]  mode_nxt;
    logic [11:0] value_nxt;
    logic [6:0]  grant_nxt;
    logic        valid_nxt;
    logic        err_nxt;

    logic [11:0] data [7];
    logic        found;
    logic [2:0]  pick;
    logic        expiry;

    assign data[0] = data0;
    assign data[1] = data1;
    assign data[2] = data2;
    assign data[3] = data3;
    assign data[4] = data4;
    assign data[5] = data5;
    assign data[6] = data6;

    // Index base+off modulo 7; base is at most 6 and off at most 7.
    function automatic logic [2:0] wrap_idx(input logic [2:0] base, input int off);
        logic [3:0] s;
        s = {1'b0, base} + off[3:0];
        return (s >= 4'd7) ? 3'(s - 4'd7) : s[2:0];
    endfunction

    always_comb begin
        found = 1'b0;
        pick  = 3'd0;
        for (int i = 1; i <= 7; i++) begin
            if (!found && req[wrap_idx(ptr, i)]) begin
                found = 1'b1;
                pick  = wrap_idx(ptr, i);
            end
        end
    end

    // hold wins over next, so a next pulse during hold is simply lost.
    assign expiry = (state == SHOW) && !hold && ((cnt == '0) || next);

    always_comb begin
        // NOTE: every output of this block gets a default first so no latch is inferred.
        state_nxt = state;
        cnt_nxt   = cnt;
        ptr_nxt   = ptr;
        mode_nxt  = mode;
        value_nxt = value;
        grant_nxt = '0;
        valid_nxt = valid;
        err_nxt   = 1'b0;

        if (found && (state != SHOW || expiry)) begin
            grant_nxt = 7'd1 << pick;
            ptr_nxt   = pick;
            if (data[pick][11:10] == TAG_ILLEGAL) begin
                err_nxt   = 1'b1;
                state_nxt = valid ? WAIT : IDLE;
            end else begin
                value_nxt = data[pick];
                mode_nxt  = pick;
                valid_nxt = 1'b1;
                cnt_nxt   = DWELL_LOAD;
                state_nxt = SHOW;
            end
        end else if (state == SHOW && !hold) begin
            if (expiry) begin
                state_nxt = WAIT;
            end else begin
                cnt_nxt = cnt - 26'd1;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            ptr   <= 3'd6;
            mode  <= 3'd0;
            value <= 12'h800;
            grant <= '0;
            valid <= 1'b0;
            err   <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            ptr   <= ptr_nxt;
            mode  <= mode_nxt;
            value <= value_nxt;
            grant <= grant_nxt;
            valid <= valid_nxt;
            err   <= err_nxt;
        end
    end

endmodule
